tristate_bus_arbiter: RTL and testbench

//   Shares one tri-state bus between NUM_REQ drivers.

---
 rtl/tristate_bus_arbiter_pkg.sv | 15 +
 rtl/tristate_bus_arbiter_if.sv | 25 ++
 rtl/tristate_bus_arbiter_rr_priority_pick.sv | 32 +++
 rtl/tristate_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_tristate_bus_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared types and helpers for the tri-state bus arbiter.
package tristate_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE       = 2'd0,
        ARB_GRANT      = 2'd1,
        ARB_TURNAROUND = 2'd2
    } arb_state_e;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Requester/arbiter bundle: level requests in, one-hot pad enables and owner out.
interface tristate_bus_arbiter_if
    import tristate_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        drive_en;
    logic                      bus_idle;
    logic [idx_w(NUM_REQ)-1:0] owner_id;

    modport master (
        input  req,
        output drive_en,
        output bus_idle,
        output owner_id
    );

    modport slave (
        output req,
        input  drive_en,
        input  bus_idle,
        input  owner_id
    );
endinterface

// File: rtl/tristate_bus_arbiter_rr_priority_pick.sv
// Round-robin pick: first set request at or after rr_ptr, wrapping to index 0.
module rr_priority_pick
    import tristate_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      rr_ptr_i,
    output logic               any_req_o,
    output logic [IW-1:0]      pick_idx_o
);

    logic [NUM_REQ-1:0] upper_mask;
    logic [NUM_REQ-1:0] upper_req;
    logic [NUM_REQ-1:0] search_req;

    // Requests at or above the pointer win; otherwise fall back to the wrapped set.
    always_comb begin
        upper_mask = ~((NUM_REQ'(1) << rr_ptr_i) - NUM_REQ'(1));
        upper_req  = req_i & upper_mask;
        search_req = (|upper_req) ? upper_req : req_i;
        any_req_o  = |req_i;
        pick_idx_o = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (search_req[i]) begin
                pick_idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus with a forced all-released gap
// between owners and an optional hold limit when others are waiting.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   IDLE       | bus released, nobody requesting; grant on first request
//   GRANT      | drive_en[owner] high; release on req drop or hold limit
//   TURNAROUND | bus released for TURNAROUND cycles, arbitrate on the last
module tristate_bus_arbiter
    import tristate_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    tristate_bus_arbiter_if.master bus
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int TW = $clog2(TURNAROUND + 1);

    localparam logic [1:0] ST_IDLE       = ARB_IDLE;
    localparam logic [1:0] ST_GRANT      = ARB_GRANT;
    localparam logic [1:0] ST_TURNAROUND = ARB_TURNAROUND;

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("tristate_bus_arbiter: NUM_REQ must be >= 2");
    end
    if (TURNAROUND < 1) begin : g_bad_turnaround
        $error("tristate_bus_arbiter: TURNAROUND must be >= 1");
    end

    logic [1:0]         state_q,    state_d;
    logic [NUM_REQ-1:0] drive_en_q, drive_en_d;
    logic               bus_idle_q, bus_idle_d;
    logic [IW-1:0]      owner_q,    owner_d;
    logic [IW-1:0]      rr_ptr_q,   rr_ptr_d;
    logic [HW-1:0]      hold_q,     hold_d;
    logic [TW-1:0]      ta_q,       ta_d;

    logic               any_req;
    logic [IW-1:0]      pick_idx;
    logic               others_req;
    logic               hold_hit;
    logic               owner_drop;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i      (bus.req),
        .rr_ptr_i   (rr_ptr_q),
        .any_req_o  (any_req),
        .pick_idx_o (pick_idx)
    );

    // drive_en_q is the owner's one-hot mask while in GRANT.
    assign others_req = |(bus.req & ~drive_en_q);
    assign hold_hit   = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD));
    assign owner_drop = !bus.req[owner_q];

    always_comb begin
        state_d    = state_q;
        drive_en_d = drive_en_q;
        bus_idle_d = bus_idle_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_d     = hold_q;
        ta_d       = ta_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d    = ST_GRANT;
                    drive_en_d = NUM_REQ'(1) << pick_idx;
                    bus_idle_d = 1'b0;
                    owner_d    = pick_idx;
                    hold_d     = HW'(1);
                end
            end

            ST_GRANT: begin
                if (owner_drop || (hold_hit && others_req)) begin
                    state_d    = ST_TURNAROUND;
                    drive_en_d = '0;
                    bus_idle_d = 1'b1;
                    rr_ptr_d   = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
                    ta_d       = TW'(TURNAROUND);
                end else if ((MAX_HOLD != 0) && !hold_hit) begin
                    hold_d = hold_q + HW'(1);
                end
            end

            ST_TURNAROUND: begin
                ta_d = ta_q - TW'(1);
                if (ta_q == TW'(1)) begin
                    if (any_req) begin
                        state_d    = ST_GRANT;
                        drive_en_d = NUM_REQ'(1) << pick_idx;
                        bus_idle_d = 1'b0;
                        owner_d    = pick_idx;
                        hold_d     = HW'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d    = ST_IDLE;
                drive_en_d = '0;
                bus_idle_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            drive_en_q <= '0;
            bus_idle_q <= 1'b1;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            hold_q     <= '0;
            ta_q       <= '0;
        end else begin
            state_q    <= state_d;
            drive_en_q <= drive_en_d;
            bus_idle_q <= bus_idle_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_q     <= hold_d;
            ta_q       <= ta_d;
        end
    end

    assign bus.drive_en = drive_en_q;
    assign bus.bus_idle = bus_idle_q;
    assign bus.owner_id = owner_q;

    a_onehot: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        $onehot0(drive_en_q));

    a_idle_match: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        bus_idle_q == (drive_en_q == '0));

    a_no_handover: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (drive_en_q != '0) |=> ((drive_en_q == '0) || $stable(drive_en_q)));

    // Zero cycles seen since the bus was last driven; 0 means "was driving".
    int gap_run_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            gap_run_q <= TURNAROUND;
        end else if (drive_en_q == '0) begin
            gap_run_q <= (gap_run_q < TURNAROUND) ? gap_run_q + 1 : gap_run_q;
        end else begin
            a_gap: assert (gap_run_q == 0 || gap_run_q >= TURNAROUND);
            gap_run_q <= 0;
        end
    end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Scoreboard bench: stimulus pushes hand-computed per-edge expectations,
// a negedge monitor pops and compares them against the two arbiter instances.
module tb_tristate_bus_arbiter;

    typedef struct packed {
        logic [3:0] de;
        logic [1:0] own;
        logic       own_valid;
        logic [15:0] id;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a;
    exp_t e_b;

    int checks = 0;
    int errors = 0;
    int step_id = 0;

    tristate_bus_arbiter_if #(.NUM_REQ(4)) bus_a ();
    tristate_bus_arbiter_if #(.NUM_REQ(4)) bus_b ();

    tristate_bus_arbiter #(
        .NUM_REQ    (4),
        .TURNAROUND (1),
        .MAX_HOLD   (8)
    ) dut_a (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_a)
    );

    tristate_bus_arbiter #(
        .NUM_REQ    (4),
        .TURNAROUND (3),
        .MAX_HOLD   (8)
    ) dut_b (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_b)
    );

    always #5 clk = ~clk;

    task automatic compare(input string tag, input exp_t e, input logic [3:0] de,
                           input logic idle, input logic [1:0] own);
        checks++;
        if (de !== e.de) begin
            errors++;
            $display("FAIL %s drive_en step %0d: got %b expected %b", tag, e.id, de, e.de);
        end
        checks++;
        if (idle !== (e.de == 4'b0000)) begin
            errors++;
            $display("FAIL %s bus_idle step %0d: got %b expected %b", tag, e.id, idle,
                     (e.de == 4'b0000));
        end
        if (e.own_valid) begin
            checks++;
            if (own !== e.own) begin
                errors++;
                $display("FAIL %s owner_id step %0d: got %0d expected %0d", tag, e.id, own, e.own);
            end
        end
    endtask

    always @(negedge clk) begin
        if (q_a.size() != 0) begin
            e_a = q_a.pop_front();
            compare("A", e_a, bus_a.drive_en, bus_a.bus_idle, bus_a.owner_id);
        end
        if (q_b.size() != 0) begin
            e_b = q_b.pop_front();
            compare("B", e_b, bus_b.drive_en, bus_b.bus_idle, bus_b.owner_id);
        end
    end

    // Apply inputs, take one edge, then queue what that edge must produce.
    task automatic step(input bit use_b, input logic rstn, input logic [3:0] r,
                        input logic [3:0] exp_de, input logic [1:0] exp_own);
        exp_t e;
        rst_n = rstn;
        if (use_b) bus_b.req = r;
        else       bus_a.req = r;
        @(posedge clk);
        step_id++;
        e.de        = exp_de;
        e.own       = exp_own;
        e.own_valid = (exp_de != 4'b0000) || !rstn;
        e.id        = 16'(step_id);
        if (use_b) q_b.push_back(e);
        else       q_a.push_back(e);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] oh;
        rst_n     = 1'b0;
        bus_a.req = 4'b0000;
        bus_b.req = 4'b0000;

        // reset state
        step(0, 0, 4'b0000, 4'b0000, 2'd0);
        step(0, 0, 4'b0000, 4'b0000, 2'd0);

        // single requester: grant after one edge, release on drop
        step(0, 1, 4'b0001, 4'b0001, 2'd0);
        for (int i = 0; i < 3; i++) step(0, 1, 4'b0001, 4'b0001, 2'd0);
        step(0, 1, 4'b0000, 4'b0000, 2'd0);
        step(0, 1, 4'b0000, 4'b0000, 2'd0);

        // two contenders: preempt after MAX_HOLD cycles, one-cycle gap each time
        step(0, 0, 4'b0000, 4'b0000, 2'd0);
        for (int i = 0; i < 8; i++) step(0, 1, 4'b0011, 4'b0001, 2'd0);
        step(0, 1, 4'b0011, 4'b0000, 2'd0);
        for (int i = 0; i < 8; i++) step(0, 1, 4'b0011, 4'b0010, 2'd1);
        step(0, 1, 4'b0011, 4'b0000, 2'd0);
        step(0, 1, 4'b0011, 4'b0001, 2'd0);
        step(0, 1, 4'b0000, 4'b0000, 2'd0);
        step(0, 1, 4'b0000, 4'b0000, 2'd0);

        // all requesting, each owner drops after two cycles: order 0,1,2,3,0
        step(0, 0, 4'b0000, 4'b0000, 2'd0);
        for (int o = 0; o < 4; o++) begin
            oh = 4'b0001 << o;
            step(0, 1, 4'b1111, oh, 2'(o));
            step(0, 1, 4'b1111, oh, 2'(o));
            step(0, 1, 4'b1111 & ~oh, 4'b0000, 2'd0);
        end
        step(0, 1, 4'b1111, 4'b0001, 2'd0);
        step(0, 1, 4'b1111, 4'b0001, 2'd0);
        step(0, 1, 4'b0000, 4'b0000, 2'd0);
        step(0, 1, 4'b0000, 4'b0000, 2'd0);

        // reset while owner 1 drives; next grant restarts at index 0
        step(0, 1, 4'b1111, 4'b0010, 2'd1);
        step(0, 1, 4'b1111, 4'b0010, 2'd1);
        step(0, 0, 4'b1111, 4'b0000, 2'd0);
        step(0, 1, 4'b1111, 4'b0001, 2'd0);
        step(0, 1, 4'b0000, 4'b0000, 2'd0);
        step(0, 1, 4'b0000, 4'b0000, 2'd0);

        // TURNAROUND=3 instance: three released cycles before the waiting requester
        step(1, 0, 4'b0000, 4'b0000, 2'd0);
        step(1, 1, 4'b0001, 4'b0001, 2'd0);
        step(1, 1, 4'b0101, 4'b0001, 2'd0);
        step(1, 1, 4'b0100, 4'b0000, 2'd0);
        step(1, 1, 4'b0100, 4'b0000, 2'd0);
        step(1, 1, 4'b0100, 4'b0000, 2'd0);
        step(1, 1, 4'b0100, 4'b0100, 2'd2);
        step(1, 1, 4'b0100, 4'b0100, 2'd2);
        step(1, 1, 4'b0000, 4'b0000, 2'd0);
        for (int i = 0; i < 3; i++) step(1, 1, 4'b0000, 4'b0000, 2'd0);

        // uncontested hold saturates; a late competitor preempts at once
        for (int i = 0; i < 12; i++) step(1, 1, 4'b0001, 4'b0001, 2'd0);
        step(1, 1, 4'b0011, 4'b0000, 2'd0);
        step(1, 1, 4'b0011, 4'b0000, 2'd0);
        step(1, 1, 4'b0011, 4'b0000, 2'd0);
        step(1, 1, 4'b0011, 4'b0010, 2'd1);
        step(1, 1, 4'b0000, 4'b0000, 2'd0);

        // random traffic exercises the in-RTL invariants
        rst_n = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            bus_a.req = 4'($urandom_range(0, 15));
            bus_b.req = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        #1;
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0",
                     q_a.size(), q_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
